// File: rtl/multibyte_addsub_seq_if.sv
// Operand/result handshake bundle for multibyte_addsub_seq.
// master = operand producer and result consumer; slave = the arithmetic block.
interface multibyte_addsub_seq_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;

  // Both channels are plain valid/ready: a transfer happens on a rising edge
  // where valid and ready are both 1; a source holds its payload until then.
  modport master (
    output in_valid, a, b, op_sub, out_ready,
    input  in_ready, out_valid, result, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, op_sub, out_ready,
    output in_ready, out_valid, result, cout, ovf, zero
  );
endinterface

// File: rtl/multibyte_addsub_seq.sv
// Byte-serial add/subtract: one 8-bit slice per clock, carry chained through a register.
// Operands are captured on accept; the result and flags are held until the consumer takes them.
module multibyte_addsub_seq #(
  parameter int NBYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  multibyte_addsub_seq_if.slave   bus,
  output logic [1:0]              dbg_state
);
  localparam int W = 8 * NBYTES;
  localparam logic [2:0] K_LAST = 3'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t       state_q;
  state_t       state_d;

  logic [W-1:0] a_q;
  logic [W-1:0] bx_q;
  logic         carry_q;
  logic [2:0]   k_q;
  logic [W-1:0] result_q;
  logic         cout_q;
  logic         ovf_q;
  logic         zero_q;

  logic [7:0]   a_byte;
  logic [7:0]   b_byte;
  logic [8:0]   slice_sum;
  logic [W-1:0] result_merged;
  logic         last_byte;
  logic         ovf_d;
  logic         zero_d;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_d = RUN;
      RUN:  if (last_byte) state_d = HOLD;
      HOLD: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == HOLD);
    dbg_state     = state_q;
  end

  // ---------------------------------------------------------------------------
  // Byte slice: the current byte of a, the current byte of the (possibly
  // inverted) b, and the chained carry. For subtract the initial carry is 1,
  // which completes the two's-complement negation of b.
  // ---------------------------------------------------------------------------
  always_comb begin
    a_byte        = a_q[8*k_q +: 8];
    b_byte        = bx_q[8*k_q +: 8];
    slice_sum     = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry_q};
    result_merged = result_q;
    result_merged[8*k_q +: 8] = slice_sum[7:0];
    last_byte     = (k_q == K_LAST);
    // On the last slice, slice_sum[7] is the sign bit of the full result.
    ovf_d         = (a_q[W-1] == bx_q[W-1]) && (slice_sum[7] != a_q[W-1]);
    zero_d        = (result_merged == '0);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      bx_q     <= '0;
      carry_q  <= 1'b0;
      k_q      <= 3'd0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            bx_q    <= bus.b ^ {W{bus.op_sub}};
            carry_q <= bus.op_sub;
            k_q     <= 3'd0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
          end
        end
        RUN: begin
          result_q <= result_merged;
          carry_q  <= slice_sum[8];
          if (last_byte) begin
            k_q    <= 3'd0;
            cout_q <= slice_sum[8];
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
          end else begin
            k_q    <= k_q + 3'd1;
          end
        end
        default: begin
          // HOLD keeps everything frozen until the consumer takes the result.
        end
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_multibyte_addsub_seq.sv
// Directed and model-checked stimulus for multibyte_addsub_seq at NBYTES=4 and NBYTES=2.
module tb_multibyte_addsub_seq;
  logic       clk;
  logic       rst;
  logic [1:0] st4;
  logic [1:0] st2;
  int         checks;
  int         errors;

  multibyte_addsub_seq_if #(.NBYTES(4)) bus4 ();
  multibyte_addsub_seq_if #(.NBYTES(2)) bus2 ();

  multibyte_addsub_seq #(.NBYTES(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus4),
    .dbg_state (st4)
  );

  multibyte_addsub_seq #(.NBYTES(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus2),
    .dbg_state (st2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input bit iv, input logic [63:0] av, input logic [63:0] bv,
                       input bit sub, input bit ordy);
    if (sel == 4) begin
      bus4.in_valid  = iv;
      bus4.a         = av[31:0];
      bus4.b         = bv[31:0];
      bus4.op_sub    = sub;
      bus4.out_ready = ordy;
    end else begin
      bus2.in_valid  = iv;
      bus2.a         = av[15:0];
      bus2.b         = bv[15:0];
      bus2.op_sub    = sub;
      bus2.out_ready = ordy;
    end
  endtask

  task automatic sample(input int sel, output logic [63:0] r, output logic c, output logic o,
                        output logic z, output logic ov, output logic ir, output logic [1:0] st);
    if (sel == 4) begin
      r = {32'd0, bus4.result}; c = bus4.cout; o = bus4.ovf; z = bus4.zero;
      ov = bus4.out_valid; ir = bus4.in_ready; st = st4;
    end else begin
      r = {48'd0, bus2.result}; c = bus2.cout; o = bus2.ovf; z = bus2.zero;
      ov = bus2.out_valid; ir = bus2.in_ready; st = st2;
    end
  endtask

  // Golden W+1-bit sum/difference; overflow from operand/result signs.
  task automatic golden(input int sel, input logic [63:0] av, input logic [63:0] bv, input bit sub,
                        output logic [63:0] r, output logic c, output logic o, output logic z);
    int          w;
    logic [63:0] mask;
    logic [64:0] s;
    logic        sa, sb, sr;
    w    = 8 * sel;
    mask = (sel == 4) ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_0000_FFFF;
    if (sub) s = {1'b0, av & mask} - {1'b0, bv & mask} + {1'b0, mask} + 65'd1;
    else     s = {1'b0, av & mask} + {1'b0, bv & mask};
    r  = s[63:0] & mask;
    c  = s[w];
    sa = av[w-1];
    sb = bv[w-1];
    sr = r[w-1];
    o  = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    z  = (r == 64'd0);
  endtask

  // One complete operation with latency, hold-stability and handshake checks.
  task automatic do_op(input string tag, input int sel, input logic [63:0] av, input logic [63:0] bv,
                       input bit sub, input logic [63:0] er, input logic ec, input logic eo,
                       input logic ez, input int hold, input bit noisy);
    logic [63:0] r;
    logic        c, o, z, ov, ir;
    logic [1:0]  st;
    int          n;
    int          lat;
    drive(sel, 1'b1, av, bv, sub, 1'b0);
    sample(sel, r, c, o, z, ov, ir, st);
    n = 0;
    while (!ir && n < 50) begin
      @(posedge clk); @(negedge clk);
      sample(sel, r, c, o, z, ov, ir, st);
      n++;
    end
    check({tag, ".in_ready"}, {63'd0, ir}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    sample(sel, r, c, o, z, ov, ir, st);
    lat = 0;
    while (!ov && lat < 20) begin
      if (noisy) drive(sel, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else       drive(sel, 1'b0, av, bv, sub, 1'b0);
      check({tag, ".in_ready_run"}, {63'd0, ir}, 64'd0);
      @(posedge clk);
      lat++;
      @(negedge clk);
      sample(sel, r, c, o, z, ov, ir, st);
    end
    drive(sel, 1'b0, noisy ? {$urandom, $urandom} : av, bv, sub, 1'b0);
    check({tag, ".latency"}, 64'(lat), 64'(sel));
    check({tag, ".result"}, r, er);
    check({tag, ".flags"}, {61'd0, c, o, z}, {61'd0, ec, eo, ez});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      sample(sel, r, c, o, z, ov, ir, st);
      check({tag, ".hold"}, {ov, ir, c, o, z, r[58:0]}, {1'b1, 1'b0, ec, eo, ez, er[58:0]});
    end
    drive(sel, 1'b0, av, bv, sub, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, av, bv, sub, 1'b0);
    sample(sel, r, c, o, z, ov, ir, st);
    check({tag, ".after_xfer"}, {60'd0, ir, ov, st}, {60'd0, 1'b1, 1'b0, 2'd0});
  endtask

  initial begin
    logic [63:0] r, er, av, bv;
    logic        c, o, z, ov, ir, ec, eo, ez;
    logic [1:0]  st;
    bit          sub;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(4, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    drive(2, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    sample(4, r, c, o, z, ov, ir, st);
    check("reset4", {r[31:0], c, o, z, ov, ir, st}, {32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0});
    sample(2, r, c, o, z, ov, ir, st);
    check("reset2", {r[15:0], c, o, z, ov, ir, st}, {16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0});

    do_op("add_carry", 4, 64'h0000_00FF, 64'h0000_0001, 1'b0, 64'h0000_0100, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    do_op("sub_zero",  4, 64'h1234_5678, 64'h1234_5678, 1'b1, 64'h0000_0000, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    do_op("sub_borrow", 4, 64'h0000_0000, 64'h0000_0001, 1'b1, 64'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    do_op("add_ovf",   4, 64'h7FFF_FFFF, 64'h0000_0001, 1'b0, 64'h8000_0000, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    do_op("sub_ovf",   4, 64'h8000_0000, 64'h0000_0001, 1'b1, 64'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    do_op("backpress", 4, 64'h89AB_CDEF, 64'h1234_5678, 1'b0, 64'h9BE0_2467, 1'b0, 1'b0, 1'b0, 5, 1'b1);
    do_op("nb2_wrap",  2, 64'h0000_FFFF, 64'h0000_0001, 1'b0, 64'h0000_0000, 1'b1, 1'b0, 1'b1, 2, 1'b0);
    do_op("nb2_ovf",   2, 64'h0000_8000, 64'h0000_0001, 1'b1, 64'h0000_7FFF, 1'b1, 1'b1, 1'b0, 0, 1'b0);

    // Reset landing on the second RUN edge must abandon the operation.
    drive(4, 1'b1, 64'h0000_1111, 64'h0000_2222, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(4, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sample(4, r, c, o, z, ov, ir, st);
    check("rst_mid", {r[31:0], c, o, z, ov, ir, st}, {32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0});
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      sample(4, r, c, o, z, ov, ir, st);
      check("rst_no_valid", {62'd0, ov, ir}, {62'd0, 1'b0, 1'b1});
    end
    do_op("after_rst", 4, 64'hFFFF_FFFF, 64'h0000_0001, 1'b0, 64'h0000_0000, 1'b1, 1'b0, 1'b1, 0, 1'b0);

    // Randomised operands, gaps and backpressure against the golden model.
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = (i % 2 == 0) ? 4 : 2;
      av  = {32'd0, $urandom};
      bv  = {32'd0, $urandom};
      if (i % 7 == 0) bv = av;
      sub = 1'($urandom_range(0, 1));
      golden(sel, av, bv, sub, er, ec, eo, ez);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_op("rand", sel, av, bv, sub, er, ec, eo, ez, $urandom_range(0, 3), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so a stuck handshake still produces a report.
  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish, expected finish before time limit");
    $fatal(1, "time limit");
  end
endmodule
